pipe_stage_skid_reg: RTL

- Parametrised successor to the fixed-field stage registers between pipeline stages (ID/EXE, EXE/MEM, MEM/WB).
- Carries a control bundle and a data bundle with a valid/ready handshake and a 2-entry skid buffer, giving full throughput with registered ready.
- Synchronous flush kills in-flight entries, and control bits read as zero whenever no entry is held, so WB_en/MEM_R_EN/MEM_W_EN-style bits cannot leak.
- Replaces per-field single-bit/32-bit register instances.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_stage_slot.sv | 54 +++++
 rtl/pipe_stage_skid_reg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline registers.
//   - Field widths of the EXE/MEM bundle (register address, machine word).
//   - EXE/MEM control bit positions (WB_EN, MEM_R_EN, MEM_W_EN).
//   - Stage occupancy state encoding used by pipe_stage_skid_reg.
//   - Saturating increment helper used by the optional stall counter,
//     which is built only when PIPE_STAGE_PERF_CNT_EN is defined.
package pipe_pkg;

   localparam int unsigned REG_ADDR_W     = 4;
   localparam int unsigned WORD_W         = 32;

   localparam int unsigned WB_EN          = 0;
   localparam int unsigned MEM_R_EN       = 1;
   localparam int unsigned MEM_W_EN       = 2;
   localparam int unsigned EXE_MEM_CTRL_W = 3;

   // ALU result + store value + destination register
   localparam int unsigned EXE_MEM_DATA_W = 2 * WORD_W + REG_ADDR_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // no entry held
      ST_FULL  = 2'd1,   // main slot holds an entry
      ST_SKID  = 2'd2    // main and skid slots both hold entries
   } stage_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      logic [31:0] result;
      if (value == 32'hFFFF_FFFF) begin
         result = value;
      end else begin
         result = value + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one storage entry (control + data bundle).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears ctrl and data
//   load       capture d_ctrl/d_data
//   clear_ctrl force the control bits to zero (wins over load);
//              data is left alone because only control bits have side effects
//   d_ctrl     control bundle to capture
//   d_data     data bundle to capture
//   q_ctrl     held control bundle
//   q_data     held data bundle
module pipe_stage_slot
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = EXE_MEM_CTRL_W,
   parameter int unsigned DATA_W = EXE_MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear_ctrl,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [DATA_W-1:0] q_data
);

   logic [CTRL_W-1:0] ctrl_r;
   logic [DATA_W-1:0] data_r;

   // Control storage: clear has priority so a killed entry never exposes stale enables.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_r <= {CTRL_W{1'b0}};
      end else if (clear_ctrl) begin
         ctrl_r <= {CTRL_W{1'b0}};
      end else if (load) begin
         ctrl_r <= d_ctrl;
      end
   end

   // Data storage: only reset or a load changes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_r <= {DATA_W{1'b0}};
      end else if (load) begin
         data_r <= d_data;
      end
   end

   assign q_ctrl = ctrl_r;
   assign q_data = data_r;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline stage register with a 2-entry
// skid buffer. Full throughput with in_ready driven straight from a flop.
// Control bits read as zero whenever the stage holds no entry.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   flush               synchronous kill of all held entries
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   in_ctrl/in_data     upstream control/data bundles
//   out_valid/out_ready downstream handshake
//   out_ctrl/out_data   main slot contents (ctrl zero when out_valid=0)
//   stall_cnt           saturating count of out_valid & !out_ready cycles,
//                       present only when PIPE_STAGE_PERF_CNT_EN is defined
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = EXE_MEM_CTRL_W,
   parameter int unsigned DATA_W = EXE_MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   stage_state_e      state_r;
   stage_state_e      state_next_s;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              accept_s;
   logic              drain_s;
   logic              main_load_s;
   logic              main_clear_s;
   logic              main_from_skid_s;
   logic              skid_load_s;
   logic              skid_clear_s;
   logic [CTRL_W-1:0] main_d_ctrl_s;
   logic [DATA_W-1:0] main_d_data_s;
   logic [CTRL_W-1:0] skid_ctrl_s;
   logic [DATA_W-1:0] skid_data_s;

   assign accept_s = in_valid & in_ready_r;
   assign drain_s  = out_valid_r & out_ready;

   // Next-state and slot-control decode; flush overrides everything.
   always_comb begin
      state_next_s     = state_r;
      main_load_s      = 1'b0;
      main_clear_s     = 1'b0;
      main_from_skid_s = 1'b0;
      skid_load_s      = 1'b0;
      skid_clear_s     = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               main_load_s  = 1'b1;
               state_next_s = ST_FULL;
            end else begin
               state_next_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (accept_s && drain_s) begin
               main_load_s  = 1'b1;
               state_next_s = ST_FULL;
            end else if (accept_s) begin
               skid_load_s  = 1'b1;
               state_next_s = ST_SKID;
            end else if (drain_s) begin
               // Going empty: zero the control bits so out_ctrl reads 0.
               main_clear_s = 1'b1;
               state_next_s = ST_EMPTY;
            end else begin
               state_next_s = ST_FULL;
            end
         end
         ST_SKID: begin
            if (drain_s) begin
               main_load_s      = 1'b1;
               main_from_skid_s = 1'b1;
               skid_clear_s     = 1'b1;
               state_next_s     = ST_FULL;
            end else begin
               state_next_s = ST_SKID;
            end
         end
         default: begin
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
            state_next_s = ST_EMPTY;
         end
      endcase
      if (flush) begin
         // Anything accepted this cycle is dropped along with held entries.
         main_load_s  = 1'b0;
         skid_load_s  = 1'b0;
         main_clear_s = 1'b1;
         skid_clear_s = 1'b1;
         state_next_s = ST_EMPTY;
      end else begin
         state_next_s = state_next_s;
      end
   end

   // Occupancy state with handshake outputs registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s != ST_SKID);
         out_valid_r <= (state_next_s != ST_EMPTY);
      end
   end

   assign main_d_ctrl_s = main_from_skid_s ? skid_ctrl_s : in_ctrl;
   assign main_d_data_s = main_from_skid_s ? skid_data_s : in_data;

   pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (main_load_s),
      .clear_ctrl (main_clear_s),
      .d_ctrl     (main_d_ctrl_s),
      .d_data     (main_d_data_s),
      .q_ctrl     (out_ctrl),
      .q_data     (out_data)
   );

   pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load_s),
      .clear_ctrl (skid_clear_s),
      .d_ctrl     (in_ctrl),
      .d_data     (in_data),
      .q_ctrl     (skid_ctrl_s),
      .q_data     (skid_data_s)
   );

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt_r;

   // Stall counter: reset-only clear, deliberately untouched by flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_r <= 32'd0;
      end else if (out_valid_r && !out_ready) begin
         stall_cnt_r <= sat_inc32(stall_cnt_r);
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

endmodule
